fore_box_overlay: RTL and testbench
===================================

# fore_box_overlay

Draws foreground bounding boxes onto the live VGA pixel stream. It sits directly downstream of the SRAM/wrapper controller and consumes its foreground byte stream (`o_fore`/`o_fore_valid`), which carries 15 boxes of 4 bytes each. Boxes are assembled into a shadow table, swapped into an active table at frame start, and compared against every incoming pixel. Matching pixels are recoloured before the stream reaches the VGA output.

## Interface
Parameters:
- NUM_BOXES, 15, boxes per set (4 bytes each; one set = 4*NUM_BOXES bytes)
- COORD_SHIFT, 2, byte-to-pixel scale (pixel coordinate = byte << COORD_SHIFT)
- BORDER, 2, border thickness in pixels (1..7)
- BOX_R / BOX_G / BOX_B, 10'h3FF / 10'h000 / 10'h000, box colour

Ports:
- i_vga_clk  in  1  pixel clock; all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_fore  in  8  foreground byte; order per box is x1, y1, x2, y2
- i_fore_valid  in  1  i_fore qualifier, one byte per asserted cycle
- i_clear  in  1  synchronous; aborts the load and invalidates all active boxes
- i_red / i_green / i_blue  in  10 each  input pixel
- i_horizon / i_vertical  in  13 each  pixel coordinates
- i_valid  in  1  pixel qualifier
- o_red / o_green / o_blue  out  10 each  output pixel
- o_valid  out  1  i_valid delayed 1 cycle
- o_box_count  out  4  number of valid boxes in the active table
- o_loaded  out  1  high once any set has been swapped in

## Operation
- **Load path**
  - A byte counter (0..4*NUM_BOXES-1) advances on each i_fore_valid.
  - Byte k is written to shadow entry k/4, field k%4.
  - On the last byte the counter wraps to 0 and `pending` is set.
- **Box validity**
  - Requires x2 >= x1, y2 >= y1, and not all four bytes zero.
  - Invalid boxes are stored but never hit.
- **Swap**
  - Frame start is i_valid && i_horizon==0 && i_vertical==0.
  - If `pending` was set on an earlier cycle: copy shadow to active, clear `pending`, set o_loaded, and update o_box_count to the popcount of the valid flags.
  - If commit and frame start fall on the same cycle, the swap waits for the next frame start.
  - A set arriving while `pending` is already set overwrites the shadow. The latest complete set wins.
- **Scaling**
  - X1 = {x1, COORD_SHIFT zeros}.
  - X2 = {x2, COORD_SHIFT ones} (inclusive end). Y1 and Y2 are scaled the same way.
  - Coordinates are 8+COORD_SHIFT bits, zero-extended to 13 bits for comparison.
- **Hit test** (combinational over all active boxes, then OR-reduced)
  - Inside: X1 <= h <= X2 and Y1 <= v <= Y2.
  - Border: inside and any of (h-X1), (X2-h), (v-Y1), (Y2-v) is < BORDER.
- **Output**: on a border hit, output BOX_R/G/B; otherwise pass the input pixel through.
- **i_clear**
  - Resets the byte counter and `pending`, clears all active valid flags, sets o_box_count=0.
  - o_loaded is unchanged.
  - Overrides an i_fore_valid byte in the same cycle; that byte is dropped.

## Timing
- Pixel latency is exactly 1 cycle. o_* reflect the i_* pixel from the previous cycle, with no bubbles.
- Pixels arriving while i_valid=0 are still registered, but their hit result is forced to no-hit.
- Swap takes effect on the frame-start pixel itself: that pixel already uses the new table.
- Load bytes may arrive during active video. The active table is never modified outside a swap or i_clear, so there is no tearing.
- Reset values:
  - All o_* = 0, o_box_count=0, o_loaded=0.
  - Counter=0, `pending`=0, all valid flags=0.
  - Shadow/active coordinate contents are don't-care.
- Reset mid-load discards partial sets. After reset, output is pure passthrough until the first swap.

## Configuration
- `FORE_OVERLAY_FILL_EN`
  - Defined: interior pixels (inside but not border) are tinted to {pixel>>1} + {BOX>>1} per channel. Border pixels are still the solid box colour.
  - Undefined: interior pixels pass through unchanged and no tint logic is built.

## Test plan
- **Load and swap.** Load 60 bytes where box0 = (10,10,20,20) and the rest are zero, then run a frame. Expected:
  - o_box_count=1 after frame start.
  - Pixels (40,40), (41,60) and (83,83) → red.
  - Pixel (50,50) → passthrough.
  - Pixel (84,50) → passthrough.
- **Deferred swap.** Send the last byte on the same cycle as frame start. Expected: the old table is used for that entire frame and the new table applies at the next frame start.
- **Invalid box.** Box (30,10,20,20): not counted, never drawn. Boxes (0,0,0,0) ×15: o_box_count=0.
- **Clear mid-load.** Send 30 bytes, assert i_clear, then send 60 new bytes. Expected: the first box comes from the new stream starting at byte 0 and o_box_count is correct.
- **Latency and qualification.** Send a random pixel stream with i_valid gaps. Expected: o_valid equals i_valid delayed 1 cycle, and pixels with i_valid=0 are never recoloured.
- **Fill option.** With FORE_OVERLAY_FILL_EN defined, interior pixel R=10'h100 with BOX_R=10'h3FF → 10'h080+10'h1FF = 10'h27F. With it undefined → 10'h100.

Source files
------------

// File: rtl/fore_box_overlay.sv
// Overlays up to NUM_BOXES foreground bounding boxes onto the VGA pixel stream.
// Optional interior tint is built when FORE_OVERLAY_FILL_EN is defined.
module fore_box_overlay #(
  parameter int unsigned NUM_BOXES   = 15,
  parameter int unsigned COORD_SHIFT = 2,
  parameter int unsigned BORDER      = 2,
  parameter logic [9:0]  BOX_R       = 10'h3FF,
  parameter logic [9:0]  BOX_G       = 10'h000,
  parameter logic [9:0]  BOX_B       = 10'h000
) (
  input  logic        i_vga_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_fore,
  input  logic        i_fore_valid,
  input  logic        i_clear,
  input  logic [9:0]  i_red,
  input  logic [9:0]  i_green,
  input  logic [9:0]  i_blue,
  input  logic [12:0] i_horizon,
  input  logic [12:0] i_vertical,
  input  logic        i_valid,
  output logic [9:0]  o_red,
  output logic [9:0]  o_green,
  output logic [9:0]  o_blue,
  output logic        o_valid,
  output logic [3:0]  o_box_count,
  output logic        o_loaded
);

  localparam int unsigned NBYTES = 4 * NUM_BOXES;
  localparam int unsigned CNT_W  = $clog2(NBYTES);

  logic [CNT_W-1:0]     r_cnt;
  logic                 r_pending;
  logic [7:0]           r_sh [NUM_BOXES][4];
  logic [7:0]           r_ac [NUM_BOXES][4];
  logic [7:0]           w_tab [NUM_BOXES][4];
  logic [NUM_BOXES-1:0] r_ac_valid;
  logic [NUM_BOXES-1:0] w_sh_valid;
  logic [NUM_BOXES-1:0] w_tab_valid;
  logic [3:0]           w_sh_count;
  logic [3:0]           r_box_count;
  logic                 r_loaded;
  logic                 w_last;
  logic                 w_frame_start;
  logic                 w_swap;
  logic                 w_border;
`ifdef FORE_OVERLAY_FILL_EN
  logic                 w_inside;
`endif
  logic [9:0]           r_red, r_green, r_blue;
  logic                 r_valid;

  function automatic logic [12:0] lo_edge(input logic [7:0] b);
    return 13'({b, {COORD_SHIFT{1'b0}}});
  endfunction

  function automatic logic [12:0] hi_edge(input logic [7:0] b);
    return 13'({b, {COORD_SHIFT{1'b1}}});
  endfunction

  function automatic logic in_box(input logic [7:0] x1, y1, x2, y2,
                                  input logic [12:0] h, v);
    return (h >= lo_edge(x1)) && (h <= hi_edge(x2)) &&
           (v >= lo_edge(y1)) && (v <= hi_edge(y2));
  endfunction

  function automatic logic edge_hit(input logic [7:0] x1, y1, x2, y2,
                                    input logic [12:0] h, v);
    return in_box(x1, y1, x2, y2, h, v) &&
           (((h - lo_edge(x1)) < 13'(BORDER)) || ((hi_edge(x2) - h) < 13'(BORDER)) ||
            ((v - lo_edge(y1)) < 13'(BORDER)) || ((hi_edge(y2) - v) < 13'(BORDER)));
  endfunction

  assign w_last        = i_fore_valid && (r_cnt == CNT_W'(NBYTES - 1));
  assign w_frame_start = i_valid && (i_horizon == 13'd0) && (i_vertical == 13'd0);
  // r_pending is the registered commit, so a commit on the frame-start cycle waits a frame
  assign w_swap        = w_frame_start && r_pending && !i_clear;

  // Shadow validity and popcount
  always_comb begin
    w_sh_count = 4'd0;
    for (int i = 0; i < NUM_BOXES; i++) begin
      w_sh_valid[i] = (r_sh[i][2] >= r_sh[i][0]) && (r_sh[i][3] >= r_sh[i][1]) &&
                      (|{r_sh[i][0], r_sh[i][1], r_sh[i][2], r_sh[i][3]});
      w_sh_count    = w_sh_count + 4'(w_sh_valid[i]);
    end
  end

  // The frame-start pixel that triggers a swap already sees the new table
  always_comb begin
    w_tab_valid = w_swap ? w_sh_valid : r_ac_valid;
    for (int i = 0; i < NUM_BOXES; i++) begin
      for (int f = 0; f < 4; f++) begin
        w_tab[i][f] = w_swap ? r_sh[i][f] : r_ac[i][f];
      end
    end
  end

  always_comb begin
    w_border = 1'b0;
`ifdef FORE_OVERLAY_FILL_EN
    w_inside = 1'b0;
`endif
    for (int i = 0; i < NUM_BOXES; i++) begin
      if (i_valid && w_tab_valid[i]) begin
        w_border = w_border | edge_hit(w_tab[i][0], w_tab[i][1], w_tab[i][2], w_tab[i][3],
                                       i_horizon, i_vertical);
`ifdef FORE_OVERLAY_FILL_EN
        w_inside = w_inside | in_box(w_tab[i][0], w_tab[i][1], w_tab[i][2], w_tab[i][3],
                                     i_horizon, i_vertical);
`endif
      end
    end
  end

  // Shadow/active coordinates need no reset; only validity is tracked
  always_ff @(posedge i_vga_clk) begin
    if (i_fore_valid && !i_clear) begin
      r_sh[r_cnt[CNT_W-1:2]][r_cnt[1:0]] <= i_fore;
    end
    if (w_swap) begin
      r_ac <= r_sh;
    end
  end

  always_ff @(posedge i_vga_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_pending   <= 1'b0;
      r_ac_valid  <= '0;
      r_box_count <= 4'd0;
      r_loaded    <= 1'b0;
    end else if (i_clear) begin
      r_cnt       <= '0;
      r_pending   <= 1'b0;
      r_ac_valid  <= '0;
      r_box_count <= 4'd0;
    end else begin
      if (i_fore_valid) begin
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
      if (w_swap) begin
        r_pending   <= 1'b0;
        r_ac_valid  <= w_sh_valid;
        r_box_count <= w_sh_count;
        r_loaded    <= 1'b1;
      end
      if (w_last) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_vga_clk or posedge i_rst) begin
    if (i_rst) begin
      r_red   <= 10'd0;
      r_green <= 10'd0;
      r_blue  <= 10'd0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (w_border) begin
        r_red   <= BOX_R;
        r_green <= BOX_G;
        r_blue  <= BOX_B;
`ifdef FORE_OVERLAY_FILL_EN
      end else if (w_inside) begin
        r_red   <= 10'((i_red   >> 1) + (BOX_R >> 1));
        r_green <= 10'((i_green >> 1) + (BOX_G >> 1));
        r_blue  <= 10'((i_blue  >> 1) + (BOX_B >> 1));
`endif
      end else begin
        r_red   <= i_red;
        r_green <= i_green;
        r_blue  <= i_blue;
      end
    end
  end

  assign o_red       = r_red;
  assign o_green     = r_green;
  assign o_blue      = r_blue;
  assign o_valid     = r_valid;
  assign o_box_count = r_box_count;
  assign o_loaded    = r_loaded;

endmodule

// File: tb/tb_fore_box_overlay.sv
// Directed self-checking bench for fore_box_overlay (default 15 boxes, shift 2, border 2, red).
module tb_fore_box_overlay;

  logic        clk;
  logic        i_rst;
  logic [7:0]  i_fore;
  logic        i_fore_valid;
  logic        i_clear;
  logic [9:0]  i_red, i_green, i_blue;
  logic [12:0] i_horizon, i_vertical;
  logic        i_valid;
  logic [9:0]  o_red, o_green, o_blue;
  logic        o_valid;
  logic [3:0]  o_box_count;
  logic        o_loaded;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [9:0] BR = 10'h3FF;
  localparam logic [9:0] BG = 10'h000;
  localparam logic [9:0] BB = 10'h000;

  fore_box_overlay dut (
    .i_vga_clk   (clk),
    .i_rst       (i_rst),
    .i_fore      (i_fore),
    .i_fore_valid(i_fore_valid),
    .i_clear     (i_clear),
    .i_red       (i_red),
    .i_green     (i_green),
    .i_blue      (i_blue),
    .i_horizon   (i_horizon),
    .i_vertical  (i_vertical),
    .i_valid     (i_valid),
    .o_red       (o_red),
    .o_green     (o_green),
    .o_blue      (o_blue),
    .o_valid     (o_valid),
    .o_box_count (o_box_count),
    .o_loaded    (o_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode: 0 passthrough, 1 border, 2 interior
  function automatic logic [9:0] expc(input logic [9:0] c, input logic [9:0] box, input int mode);
    if (mode == 1) return box;
`ifdef FORE_OVERLAY_FILL_EN
    if (mode == 2) return 10'((c >> 1) + (box >> 1));
`endif
    return c;
  endfunction

  task automatic pix(input string tag, input int h, input int v, input bit vld, input int mode);
    logic [9:0] r, g, b;
    r = 10'(h + 1);
    g = 10'(v + 2);
    b = 10'h155;
    @(negedge clk);
    i_fore_valid = 1'b0;
    i_clear      = 1'b0;
    i_valid      = vld;
    i_horizon    = 13'(h);
    i_vertical   = 13'(v);
    i_red        = r;
    i_green      = g;
    i_blue       = b;
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(o_valid), 32'(vld));
    chk({tag, ".r"}, 32'(o_red),   32'(expc(r, BR, mode)));
    chk({tag, ".g"}, 32'(o_green), 32'(expc(g, BG, mode)));
    chk({tag, ".b"}, 32'(o_blue),  32'(expc(b, BB, mode)));
  endtask

  // Boxes packed as {x1,y1,x2,y2}; only entries 0, 1 and 14 are nonzero
  task automatic load_set(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b14,
                          input int nbytes, input bit fs_last);
    logic [31:0] w;
    int bx;
    int f;
    for (int k = 0; k < nbytes; k++) begin
      bx = k / 4;
      f  = k % 4;
      w  = (bx == 0) ? b0 : (bx == 1) ? b1 : (bx == 14) ? b14 : 32'h0;
      @(negedge clk);
      i_clear      = 1'b0;
      i_fore_valid = 1'b1;
      i_fore       = w[31-8*f -: 8];
      if (fs_last && (k == nbytes - 1)) begin
        i_valid    = 1'b1;
        i_horizon  = 13'd0;
        i_vertical = 13'd0;
        i_red      = 10'h0AA;
        i_green    = 10'h0BB;
        i_blue     = 10'h0CC;
      end else begin
        i_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int v;
    bit vld;
    bit sel;
    i_rst = 1'b1; i_fore = 8'd0; i_fore_valid = 1'b0; i_clear = 1'b0;
    i_red = 10'd0; i_green = 10'd0; i_blue = 10'd0;
    i_horizon = 13'd0; i_vertical = 13'd0; i_valid = 1'b0;

    #2;
    chk("rst.r", 32'(o_red), 32'h0);
    chk("rst.valid", 32'(o_valid), 32'h0);
    chk("rst.count", 32'(o_box_count), 32'h0);
    chk("rst.loaded", 32'(o_loaded), 32'h0);
    repeat (2) @(negedge clk);
    i_rst = 1'b0;

    pix("pre", 40, 40, 1'b1, 0);

    // Set A: box0 (10,10,20,20) -> pixels 40..83
    load_set(32'h0A0A1414, 32'h0, 32'h0, 60, 1'b0);
    pix("a_before_fs", 40, 40, 1'b1, 0);
    chk("a_before_fs.count", 32'(o_box_count), 32'h0);
    chk("a_before_fs.loaded", 32'(o_loaded), 32'h0);
    pix("a_fs", 0, 0, 1'b1, 0);
    chk("a_fs.count", 32'(o_box_count), 32'h1);
    chk("a_fs.loaded", 32'(o_loaded), 32'h1);
    pix("a_40_40", 40, 40, 1'b1, 1);
    pix("a_41_60", 41, 60, 1'b1, 1);
    pix("a_83_83", 83, 83, 1'b1, 1);
    pix("a_50_50", 50, 50, 1'b1, 2);
    pix("a_84_50", 84, 50, 1'b1, 0);
    pix("a_42_60", 42, 60, 1'b1, 2);
    pix("a_40_40_inv", 40, 40, 1'b0, 0);

    // Set B box0 (30,30,40,40) -> 120..163, last byte lands on frame start
    load_set(32'h1E1E2828, 32'h0, 32'h0, 60, 1'b1);
    @(posedge clk);
    #1;
    chk("defer_fs.r", 32'(o_red), 32'h0AA);
    chk("defer_fs.count", 32'(o_box_count), 32'h1);
    pix("defer_old_hit", 40, 40, 1'b1, 1);
    pix("defer_new_miss", 120, 120, 1'b1, 0);
    pix("defer_fs2", 0, 0, 1'b1, 0);
    pix("defer_new_hit", 120, 120, 1'b1, 1);
    pix("defer_old_miss", 40, 40, 1'b1, 0);

    // Clear mid-load, with a dropped byte on the clear cycle
    load_set(32'h0A0A1414, 32'h0, 32'h0, 30, 1'b0);
    @(negedge clk);
    i_clear = 1'b1; i_fore_valid = 1'b1; i_fore = 8'hFF; i_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("clr.count", 32'(o_box_count), 32'h0);
    chk("clr.loaded", 32'(o_loaded), 32'h1);
    pix("clr_miss", 120, 120, 1'b1, 0);
    pix("clr_fs", 0, 0, 1'b1, 0);
    chk("clr_fs.count", 32'(o_box_count), 32'h0);
    // Set E box0 (50,50,70,70) -> 200..283
    load_set(32'h32324646, 32'h0, 32'h0, 60, 1'b0);
    pix("e_fs", 0, 0, 1'b1, 0);
    chk("e_fs.count", 32'(o_box_count), 32'h1);
    pix("e_200_200", 200, 200, 1'b1, 1);
    pix("e_fill_255_220", 255, 220, 1'b1, 2);
    pix("e_old_miss", 120, 120, 1'b1, 0);

    // Set C: valid box0, invalid box1 (x2<x1), valid box14 (400..443)
    load_set(32'h0A0A1414, 32'h1E0A1414, 32'h64646E6E, 60, 1'b0);
    pix("c_fs", 0, 0, 1'b1, 0);
    chk("c_fs.count", 32'(o_box_count), 32'h2);
    pix("c_400_400", 400, 400, 1'b1, 1);
    pix("c_443_420", 443, 420, 1'b1, 1);
    pix("c_inv_box", 120, 40, 1'b1, 0);
    pix("c_40_40", 40, 40, 1'b1, 1);

    // All-zero set: nothing valid, (0,0) not drawn
    load_set(32'h0, 32'h0, 32'h0, 60, 1'b0);
    pix("z_fs", 0, 0, 1'b1, 0);
    chk("z_fs.count", 32'(o_box_count), 32'h0);
    pix("z_40_40", 40, 40, 1'b1, 0);

    // Back-to-back stream with i_valid gaps over box E
    load_set(32'h32324646, 32'h0, 32'h0, 60, 1'b0);
    pix("r_fs", 0, 0, 1'b1, 0);
    for (int n = 0; n < 24; n++) begin
      vld = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      v   = int'($urandom_range(200, 283));
      if (sel) pix("rnd_edge", 200, v, vld, vld ? 1 : 0);
      else     pix("rnd_inner", 230, 230, vld, vld ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
